peri_bus_fabric: RTL and testbench
==================================

Name: peri_bus_fabric

Overview:
Parametrised peripheral bus interconnect between the TRSQ8 CPU data port and N memory-mapped slaves (data RAM, SPI, GPIO, future blocks). It replaces hard-wired combinational address decoding with a registered single-master fabric. The fabric adds a per-slave ready handshake (wait states), decode-miss and timeout error reporting, and error capture registers.

Parameters:
NUM_SLAVES, 3, number of slave ports (1..8)
ADDR_W, 8, address width
DATA_W, 8, data width
SLAVE_BASE, {8'h84,8'h80,8'h00}, packed NUM_SLAVES*ADDR_W; slave i base at [i*ADDR_W +: ADDR_W]; must be aligned to region size
SLAVE_SIZE_LOG2, {4'd2,4'd2,4'd7}, packed NUM_SLAVES*4; region size of slave i = 2^value bytes
TIMEOUT, 15, max ACCESS cycles without s_ready before error (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
m_addr  in  ADDR_W  master address
m_wdata  in  DATA_W  master write data
m_wr  in  1  master write request
m_rd  in  1  master read request
m_rdata  out  DATA_W  registered read data, valid while m_ready=1
m_ready  out  1  one-cycle transaction completion pulse
m_err  out  1  error flag, qualified by m_ready
s_addr  out  ADDR_W  latched address, shared by all slaves
s_wdata  out  DATA_W  latched write data, shared
s_wr  out  NUM_SLAVES  one-hot write strobe
s_rd  out  NUM_SLAVES  one-hot read strobe
s_rdata  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
s_ready  in  NUM_SLAVES  slave completion
err_addr  out  ADDR_W  address of most recent errored transaction
err_count  out  8  saturating error counter

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; all outputs 0. Reset mid-transaction aborts on the same edge: strobes low next cycle, no m_ready.
- Decode: slave i hits when (m_addr >> SIZE_LOG2[i]) == (BASE[i] >> SIZE_LOG2[i]). Overlapping regions resolve to the lowest index. No hit = miss.
- Request priority: m_wr and m_rd both high -> write; m_rd is ignored.
- FSM:
  - IDLE: on (m_wr|m_rd), latch addr, wdata, direction and slave index. Hit -> ACCESS. Miss -> DONE with error.
  - ACCESS: s_wr[idx] or s_rd[idx] held high (one-hot); timeout counter increments each cycle.
    - s_ready[idx]=1 -> capture s_rdata[idx] (read) into m_rdata reg; -> DONE, err=0.
    - Counter reaches TIMEOUT with no ready -> DONE, err=1, rdata=0. Strobe drops on the same edge.
  - DONE: m_ready=1 for exactly one cycle; m_err valid; -> IDLE.
- Latency: hit with s_ready in the first ACCESS cycle -> m_ready 2 cycles after request sampled; each wait state adds 1; a miss gives m_ready 1 cycle after request sampled.
- Master handshake: the request is consumed at the edge where m_ready=1. The master must drop or replace the request by the following cycle; IDLE treats any request as new. Master inputs are ignored outside IDLE.
- Write data is always 0 on m_rdata; m_rdata holds its last value except during DONE, where it is updated.
- Errors: on entry to DONE with err, err_addr <= latched addr; err_count increments and saturates at 8'hFF.
- s_ready from non-selected slaves is ignored.

Optional Feature:
PBF_TIMEOUT_EN. Defined: timeout counter and timeout error as above. Undefined: no counter; ACCESS waits indefinitely for s_ready; errors come from decode misses only.

Test Plan:
- Read 0x05, slave0 s_ready immediate with rdata 0x5A -> s_rd=3'b001 for 1 cycle; m_ready 2 cycles after request; m_rdata=0x5A, m_err=0.
- Write 0x85 data 0xC3, slave2 s_ready after 3 wait cycles -> s_wr=3'b100 for 4 cycles, s_wdata=0xC3; m_ready one cycle later, m_err=0.
- Read 0x90 (miss) -> no strobe; m_ready 1 cycle after request; m_err=1, m_rdata=0, err_addr=0x90, err_count=1.
- Read 0x81 with slave1 never ready (PBF_TIMEOUT_EN defined) -> s_rd[1] high 15 cycles then low; m_err=1, err_addr=0x81. With the macro undefined, the strobe stays high until s_ready.
- m_wr=m_rd=1 at 0x84 -> only s_wr[2] asserts. 300 misses -> err_count=0xFF.
- Assert reset during ACCESS of 0x05 -> next cycle s_rd=0, m_ready=0, err_count=0; a subsequent read completes normally.

Source files
------------

// File: rtl/peri_bus_fabric_if.sv
// Peripheral bus bundle between the CPU data port, the fabric and the slaves.
// master: CPU side, slave: peripheral side, fabric: the interconnect itself.
interface peri_bus_fabric_if #(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) ();
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic                         m_wr;
    logic                         m_rd;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_ready;
    logic                         m_err;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]        s_wr;
    logic [NUM_SLAVES-1:0]        s_rd;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_ready;

    modport master (
        output m_addr, m_wdata, m_wr, m_rd,
        input  m_rdata, m_ready, m_err
    );

    modport slave (
        input  s_addr, s_wdata, s_wr, s_rd,
        output s_rdata, s_ready
    );

    modport fabric (
        input  m_addr, m_wdata, m_wr, m_rd, s_rdata, s_ready,
        output m_rdata, m_ready, m_err, s_addr, s_wdata, s_wr, s_rd
    );
endinterface

// File: rtl/peri_bus_fabric.sv
// Registered single-master peripheral interconnect: decodes the CPU address
// onto one of NUM_SLAVES regions, holds a one-hot strobe until the slave
// answers, and reports decode misses (and optionally timeouts) with error
// capture registers.
// Optional feature macro: PBF_TIMEOUT_EN -- when defined, an ACCESS that sees
// no s_ready for TIMEOUT cycles ends with an error; when undefined, ACCESS
// waits for s_ready indefinitely and the TIMEOUT parameter does not exist.
module peri_bus_fabric #(
    parameter int                          NUM_SLAVES      = 3,
    parameter int                          ADDR_W          = 8,
    parameter int                          DATA_W          = 8,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {8'h84, 8'h80, 8'h00},
    parameter logic [NUM_SLAVES*4-1:0]     SLAVE_SIZE_LOG2 = {4'd2, 4'd2, 4'd7}
`ifdef PBF_TIMEOUT_EN
    ,
    parameter int                          TIMEOUT         = 15
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    peri_bus_fabric_if.fabric    bus,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [7:0]           err_count
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_is_wr;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_SLAVES-1:0] r_s_wr;
    logic [NUM_SLAVES-1:0] r_s_rd;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_ready;
    logic                  r_err;
    logic [ADDR_W-1:0]     r_err_addr;
    logic [7:0]            r_err_count;
`ifdef PBF_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]            r_tmo_cnt;
`endif

    logic                  w_req;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_sel_ready;
    logic [7:0]            w_err_count_inc;

    assign w_req           = bus.m_wr | bus.m_rd;
    assign w_onehot        = NUM_SLAVES'(1) << w_idx;
    assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    // Address decode; scanning from the top index down lets the lowest index win overlaps.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr >> SLAVE_SIZE_LOG2[i*4 +: 4]) ==
                (SLAVE_BASE[i*ADDR_W +: ADDR_W] >> SLAVE_SIZE_LOG2[i*4 +: 4])) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    // Pick the latched slave's read data and ready; other slaves' ready is ignored.
    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
                w_sel_ready = bus.s_ready[i];
            end
        end
    end

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_s_wr      <= '0;
            r_s_rd      <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
`ifdef PBF_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (w_req) begin
                        r_addr  <= bus.m_addr;
                        r_wdata <= bus.m_wdata;
                        r_is_wr <= bus.m_wr;
                        r_idx   <= w_idx;
`ifdef PBF_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if (w_hit) begin
                            r_state <= ST_ACCESS;
                            // Write wins when both requests are raised together.
                            if (bus.m_wr) r_s_wr <= w_onehot;
                            else          r_s_rd <= w_onehot;
                        end else begin
                            r_state     <= ST_DONE;
                            r_ready     <= 1'b1;
                            r_err       <= 1'b1;
                            r_rdata     <= '0;
                            r_err_addr  <= bus.m_addr;
                            r_err_count <= w_err_count_inc;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_s_wr  <= '0;
                        r_s_rd  <= '0;
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= r_is_wr ? '0 : w_sel_rdata;
                    end
`ifdef PBF_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_s_wr      <= '0;
                        r_s_rd      <= '0;
                        r_state     <= ST_DONE;
                        r_ready     <= 1'b1;
                        r_err       <= 1'b1;
                        r_rdata     <= '0;
                        r_err_addr  <= r_addr;
                        r_err_count <= w_err_count_inc;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end
                ST_DONE: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_rdata = r_rdata;
    assign bus.m_ready = r_ready;
    assign bus.m_err   = r_err;
    assign bus.s_addr  = r_addr;
    assign bus.s_wdata = r_wdata;
    assign bus.s_wr    = r_s_wr;
    assign bus.s_rd    = r_s_rd;
    assign err_addr    = r_err_addr;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_peri_bus_fabric.sv
// Self-checking bench for peri_bus_fabric (default 3-slave map). Random
// traffic is compared against an address-range reference model.
module tb_peri_bus_fabric;

    localparam int NS      = 3;
    localparam int TMO     = 15;
    localparam int MAX_CYC = 100;

    typedef struct {
        int         lat;
        int         strobes;
        logic [2:0] or_wr;
        logic [2:0] or_rd;
        logic [7:0] saddr;
        logic [7:0] swdata;
        logic [7:0] rdata;
        logic       err;
        logic       post_ready;
        logic [7:0] post_rdata;
        bit         hung;
    } obs_t;

    typedef struct {
        int         lat;
        int         strobes;
        logic [2:0] wr;
        logic [2:0] rd;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] err_addr;
    logic [7:0] err_count;

    int         n_checks;
    int         n_errors;
    int         exp_err_count;
    logic [7:0] exp_err_addr;
    logic [7:0] slave_data [NS];

    peri_bus_fabric_if #(.NUM_SLAVES(NS), .ADDR_W(8), .DATA_W(8)) bus_if ();

    peri_bus_fabric dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    // Reference decode: first region (lowest index) whose byte range holds the address.
    function automatic int ref_decode(input logic [7:0] a);
        int base [NS] = '{0, 128, 132};
        int lg   [NS] = '{7, 2, 2};
        for (int i = 0; i < NS; i++)
            if (int'(a) >= base[i] && int'(a) < base[i] + (1 << lg[i])) return i;
        return -1;
    endfunction

    // Expected outcome of one transaction; also advances the error-capture model.
    task automatic ref_txn(input logic [7:0] addr, input logic wr, input int delay, output exp_t e);
        int idx;
        bit tmo_hit;
        idx = ref_decode(addr);
        tmo_hit = 1'b0;
        e.wr = '0; e.rd = '0; e.rdata = '0; e.err = 1'b0; e.strobes = 0; e.lat = 1;
        if (idx < 0) begin
            e.err = 1'b1;
        end else begin
`ifdef PBF_TIMEOUT_EN
            tmo_hit = (delay < 0) || (delay >= TMO);
`endif
            e.strobes = tmo_hit ? TMO : delay + 1;
            e.lat     = e.strobes + 1;
            if (wr) e.wr = 3'(1 << idx);
            else    e.rd = 3'(1 << idx);
            e.err = tmo_hit;
            if (!wr && !tmo_hit) e.rdata = slave_data[idx];
        end
        if (e.err) begin
            exp_err_addr = addr;
            if (exp_err_count < 255) exp_err_count++;
        end
    endtask

    task automatic load_slaves();
        for (int i = 0; i < NS; i++) slave_data[i] = 8'($urandom);
        bus_if.s_rdata = {slave_data[2], slave_data[1], slave_data[0]};
    endtask

    // Master + slave driver. delay<0 means the selected slave never answers.
    // Starts and ends 1 time unit after a rising edge with the fabric idle.
    task automatic run_txn(input logic [7:0] addr, input logic [7:0] wdata, input logic wr,
                           input logic rd, input int delay, input bit noise, output obs_t o);
        logic [2:0] active;
        logic [2:0] sel;
        o = '{lat: 0, strobes: 0, or_wr: '0, or_rd: '0, saddr: '0, swdata: '0,
              rdata: '0, err: 1'b0, post_ready: 1'b0, post_rdata: '0, hung: 1'b1};
        bus_if.m_addr  = addr;
        bus_if.m_wdata = wdata;
        bus_if.m_wr    = wr;
        bus_if.m_rd    = rd;
        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            @(posedge clk);
            #1;
            // The request stays raised but its address/data change: the fabric must use the latched copy.
            bus_if.m_addr  = 8'($urandom);
            bus_if.m_wdata = 8'($urandom);
            active = bus_if.s_wr | bus_if.s_rd;
            if (active != '0) begin
                o.strobes++;
                o.or_wr  |= bus_if.s_wr;
                o.or_rd  |= bus_if.s_rd;
                o.saddr  = bus_if.s_addr;
                o.swdata = bus_if.s_wdata;
            end
            sel = (active != '0 && delay >= 0 && o.strobes > delay) ? active : 3'b000;
            bus_if.s_ready = sel | (noise ? (3'($urandom) & ~active) : 3'b000);
            if (bus_if.m_ready) begin
                o.lat   = cyc;
                o.rdata = bus_if.m_rdata;
                o.err   = bus_if.m_err;
                o.hung  = 1'b0;
                bus_if.m_wr    = 1'b0;
                bus_if.m_rd    = 1'b0;
                bus_if.s_ready = '0;
                @(posedge clk);
                #1;
                o.post_ready = bus_if.m_ready;
                o.post_rdata = bus_if.m_rdata;
                break;
            end
        end
        bus_if.m_wr    = 1'b0;
        bus_if.m_rd    = 1'b0;
        bus_if.s_ready = '0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus_if.m_addr  = '0;
        bus_if.m_wdata = '0;
        bus_if.m_wr    = 1'b0;
        bus_if.m_rd    = 1'b0;
        bus_if.s_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        reset         = 1'b0;
        exp_err_count = 0;
        exp_err_addr  = '0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus_if.m_addr  = 8'h05;
        bus_if.m_wdata = 8'hEE;
        bus_if.m_wr    = 1'b0;
        bus_if.m_rd    = 1'b1;
        bus_if.s_ready = '0;
        bus_if.s_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_if.m_ready !== 1'b0) begin n_errors++; $display("FAIL reset m_ready: got %b expected 0", bus_if.m_ready); end
        n_checks++; if (bus_if.m_err !== 1'b0) begin n_errors++; $display("FAIL reset m_err: got %b expected 0", bus_if.m_err); end
        n_checks++; if (bus_if.m_rdata !== 8'h00) begin n_errors++; $display("FAIL reset m_rdata: got %h expected 00", bus_if.m_rdata); end
        n_checks++; if ((bus_if.s_wr | bus_if.s_rd) !== 3'b000) begin n_errors++; $display("FAIL reset strobes: got wr=%b rd=%b expected 000", bus_if.s_wr, bus_if.s_rd); end
        n_checks++; if ({bus_if.s_addr, bus_if.s_wdata} !== 16'h0000) begin n_errors++; $display("FAIL reset s_addr/s_wdata: got %h/%h expected 00/00", bus_if.s_addr, bus_if.s_wdata); end
        n_checks++; if ({err_addr, err_count} !== 16'h0000) begin n_errors++; $display("FAIL reset err regs: got addr=%h count=%h expected 00/00", err_addr, err_count); end
        do_reset();
    endtask

    task automatic test_read_immediate();
        obs_t o;
        load_slaves();
        slave_data[0] = 8'h5A;
        bus_if.s_rdata = {slave_data[2], slave_data[1], slave_data[0]};
        run_txn(8'h05, 8'h00, 1'b0, 1'b1, 0, 1'b1, o);
        n_checks++; if (o.hung) begin n_errors++; $display("FAIL rd_imm no m_ready: got none expected within %0d cycles", MAX_CYC); end
        n_checks++; if (o.lat !== 2) begin n_errors++; $display("FAIL rd_imm latency: got %0d expected 2", o.lat); end
        n_checks++; if (o.strobes !== 1 || o.or_rd !== 3'b001 || o.or_wr !== 3'b000) begin n_errors++; $display("FAIL rd_imm strobe: got %0d cycles rd=%b wr=%b expected 1 001 000", o.strobes, o.or_rd, o.or_wr); end
        n_checks++; if (o.saddr !== 8'h05) begin n_errors++; $display("FAIL rd_imm s_addr: got %h expected 05", o.saddr); end
        n_checks++; if (o.rdata !== 8'h5A || o.err !== 1'b0) begin n_errors++; $display("FAIL rd_imm result: got %h err=%b expected 5a err=0", o.rdata, o.err); end
        n_checks++; if (o.post_ready !== 1'b0 || o.post_rdata !== 8'h5A) begin n_errors++; $display("FAIL rd_imm after done: got ready=%b rdata=%h expected 0 5a", o.post_ready, o.post_rdata); end
    endtask

    task automatic test_write_wait();
        obs_t o;
        load_slaves();
        run_txn(8'h85, 8'hC3, 1'b1, 1'b0, 3, 1'b1, o);
        n_checks++; if (o.strobes !== 4 || o.or_wr !== 3'b100 || o.or_rd !== 3'b000) begin n_errors++; $display("FAIL wr_wait strobe: got %0d cycles wr=%b rd=%b expected 4 100 000", o.strobes, o.or_wr, o.or_rd); end
        n_checks++; if (o.swdata !== 8'hC3 || o.saddr !== 8'h85) begin n_errors++; $display("FAIL wr_wait s_wdata/s_addr: got %h/%h expected c3/85", o.swdata, o.saddr); end
        n_checks++; if (o.lat !== 5) begin n_errors++; $display("FAIL wr_wait latency: got %0d expected 5", o.lat); end
        n_checks++; if (o.err !== 1'b0 || o.rdata !== 8'h00) begin n_errors++; $display("FAIL wr_wait result: got err=%b rdata=%h expected 0 00", o.err, o.rdata); end
    endtask

    task automatic test_miss();
        obs_t o;
        exp_t e;
        load_slaves();
        slave_data[1] = 8'h77;
        bus_if.s_rdata = {slave_data[2], slave_data[1], slave_data[0]};
        run_txn(8'h81, 8'h00, 1'b0, 1'b1, 0, 1'b0, o);
        n_checks++; if (o.rdata !== 8'h77) begin n_errors++; $display("FAIL miss pre-read: got %h expected 77", o.rdata); end
        ref_txn(8'h90, 1'b0, 0, e);
        run_txn(8'h90, 8'h00, 1'b0, 1'b1, 0, 1'b1, o);
        n_checks++; if (o.lat !== 1 || o.strobes !== 0) begin n_errors++; $display("FAIL miss timing: got lat=%0d strobes=%0d expected 1 0", o.lat, o.strobes); end
        n_checks++; if (o.err !== 1'b1 || o.rdata !== 8'h00) begin n_errors++; $display("FAIL miss result: got err=%b rdata=%h expected 1 00", o.err, o.rdata); end
        n_checks++; if (err_addr !== 8'h90 || err_count !== 8'(exp_err_count)) begin n_errors++; $display("FAIL miss capture: got addr=%h count=%0d expected 90 %0d", err_addr, err_count, exp_err_count); end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        load_slaves();
        run_txn(8'h10, 8'h00, 1'b0, 1'b1, 0, 1'b0, o);
        n_checks++; if (o.rdata !== slave_data[0]) begin n_errors++; $display("FAIL tmo pre-read: got %h expected %h", o.rdata, slave_data[0]); end
`ifdef PBF_TIMEOUT_EN
        ref_txn(8'h81, 1'b0, -1, e);
        run_txn(8'h81, 8'h00, 1'b0, 1'b1, -1, 1'b1, o);
`else
        ref_txn(8'h81, 1'b0, 40, e);
        run_txn(8'h81, 8'h00, 1'b0, 1'b1, 40, 1'b1, o);
`endif
        n_checks++; if (o.hung) begin n_errors++; $display("FAIL tmo no m_ready: got none expected within %0d cycles", MAX_CYC); end
        n_checks++; if (o.strobes !== e.strobes || o.or_rd !== 3'b010) begin n_errors++; $display("FAIL tmo strobe: got %0d cycles rd=%b expected %0d 010", o.strobes, o.or_rd, e.strobes); end
        n_checks++; if (o.lat !== e.lat) begin n_errors++; $display("FAIL tmo latency: got %0d expected %0d", o.lat, e.lat); end
        n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_errors++; $display("FAIL tmo result: got err=%b rdata=%h expected %b %h", o.err, o.rdata, e.err, e.rdata); end
        n_checks++; if (err_addr !== exp_err_addr || err_count !== 8'(exp_err_count)) begin n_errors++; $display("FAIL tmo capture: got addr=%h count=%0d expected %h %0d", err_addr, err_count, exp_err_addr, exp_err_count); end
    endtask

    task automatic test_priority();
        obs_t o;
        load_slaves();
        run_txn(8'h84, 8'h3C, 1'b1, 1'b1, 1, 1'b1, o);
        n_checks++; if (o.or_wr !== 3'b100 || o.or_rd !== 3'b000) begin n_errors++; $display("FAIL prio strobes: got wr=%b rd=%b expected 100 000", o.or_wr, o.or_rd); end
        n_checks++; if (o.strobes !== 2 || o.lat !== 3) begin n_errors++; $display("FAIL prio timing: got strobes=%0d lat=%0d expected 2 3", o.strobes, o.lat); end
        n_checks++; if (o.swdata !== 8'h3C || o.rdata !== 8'h00 || o.err !== 1'b0) begin n_errors++; $display("FAIL prio data: got wdata=%h rdata=%h err=%b expected 3c 00 0", o.swdata, o.rdata, o.err); end
    endtask

    task automatic test_random();
        obs_t       o;
        exp_t       e;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] kind;
        int         delay;
        for (int n = 0; n < 50; n++) begin
            load_slaves();
            addr  = ($urandom_range(0, 1) == 0) ? 8'(8'h80 + $urandom_range(0, 15)) : 8'($urandom);
            wdata = 8'($urandom);
            kind  = 2'($urandom_range(1, 3));
`ifdef PBF_TIMEOUT_EN
            delay = $urandom_range(0, 19);
            if (delay == 19) delay = -1;
`else
            delay = $urandom_range(0, 5);
`endif
            ref_txn(addr, kind[1], delay, e);
            run_txn(addr, wdata, kind[1], kind[0], delay, 1'b1, o);
            n_checks++; if (o.hung || o.lat !== e.lat) begin n_errors++; $display("FAIL rand[%0d] latency a=%h: got %0d hung=%b expected %0d", n, addr, o.lat, o.hung, e.lat); end
            n_checks++; if (o.strobes !== e.strobes || o.or_wr !== e.wr || o.or_rd !== e.rd) begin n_errors++; $display("FAIL rand[%0d] strobes a=%h: got %0d wr=%b rd=%b expected %0d %b %b", n, addr, o.strobes, o.or_wr, o.or_rd, e.strobes, e.wr, e.rd); end
            n_checks++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_errors++; $display("FAIL rand[%0d] result a=%h: got rdata=%h err=%b expected %h %b", n, addr, o.rdata, o.err, e.rdata, e.err); end
            n_checks++; if (o.post_ready !== 1'b0 || o.post_rdata !== e.rdata) begin n_errors++; $display("FAIL rand[%0d] hold: got ready=%b rdata=%h expected 0 %h", n, o.post_ready, o.post_rdata, e.rdata); end
            if (e.strobes > 0) begin
                n_checks++; if (o.saddr !== addr || o.swdata !== wdata) begin n_errors++; $display("FAIL rand[%0d] latch: got %h/%h expected %h/%h", n, o.saddr, o.swdata, addr, wdata); end
            end
            n_checks++; if (err_addr !== exp_err_addr || err_count !== 8'(exp_err_count)) begin n_errors++; $display("FAIL rand[%0d] capture: got %h/%0d expected %h/%0d", n, err_addr, err_count, exp_err_addr, exp_err_count); end
            if (o.hung) do_reset();
        end
    endtask

    task automatic test_saturation();
        obs_t       o;
        exp_t       e;
        logic [7:0] addr;
        for (int n = 0; n < 300; n++) begin
            addr = 8'($urandom_range(8'h88, 8'hFF));
            ref_txn(addr, 1'b0, 0, e);
            run_txn(addr, 8'h00, 1'b0, 1'b1, 0, 1'b0, o);
            n_checks++; if (o.err !== 1'b1 || o.lat !== 1) begin n_errors++; $display("FAIL sat[%0d] miss: got err=%b lat=%0d expected 1 1", n, o.err, o.lat); end
        end
        n_checks++; if (err_count !== 8'hFF || exp_err_count !== 255) begin n_errors++; $display("FAIL sat count: got %h expected ff", err_count); end
        n_checks++; if (err_addr !== exp_err_addr) begin n_errors++; $display("FAIL sat err_addr: got %h expected %h", err_addr, exp_err_addr); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        load_slaves();
        bus_if.m_addr  = 8'h05;
        bus_if.m_wdata = 8'h00;
        bus_if.m_rd    = 1'b1;
        bus_if.s_ready = '0;
        @(posedge clk);
        #1;
        n_checks++; if (bus_if.s_rd !== 3'b001) begin n_errors++; $display("FAIL rstmid strobe before: got %b expected 001", bus_if.s_rd); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus_if.m_rd = 1'b0;
        exp_err_count = 0;
        exp_err_addr  = '0;
        n_checks++; if (bus_if.s_rd !== 3'b000 || bus_if.m_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid abort: got s_rd=%b m_ready=%b expected 000 0", bus_if.s_rd, bus_if.m_ready); end
        n_checks++; if (err_count !== 8'h00) begin n_errors++; $display("FAIL rstmid err_count: got %h expected 00", err_count); end
        run_txn(8'h05, 8'h00, 1'b0, 1'b1, 1, 1'b1, o);
        n_checks++; if (o.lat !== 3 || o.rdata !== slave_data[0] || o.err !== 1'b0) begin n_errors++; $display("FAIL rstmid follow-up: got lat=%0d rdata=%h err=%b expected 3 %h 0", o.lat, o.rdata, o.err, slave_data[0]); end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_err_count = 0;
        exp_err_addr  = '0;
        test_reset();
        test_read_immediate();
        test_write_wait();
        test_miss();
        test_timeout();
        test_priority();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
